// File: rtl/adder_ctrl_pkg.sv
// Purpose : shared state encoding and sizing helpers for multi-cycle adder controllers.
// Latency : n/a (types and constant functions only).
// Backpressure: n/a.
package adder_ctrl_pkg;

    // Two-bit controller state; the encoding is shared by every adder controller.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ctrl_state_e;

    // Slice counter width: clog2 of the slice count, but never narrower than one bit
    // so a single-slice controller still has a legal counter.
    function automatic int cnt_width(input int words);
        int w;
        w = $clog2(words);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/wide_add_sequencer_slice_shifter.sv
// Purpose : N-bit register with parallel load and shift-right-by-WIDTH, new slice enters at the top.
// Latency : 1 cycle (registered output).
// Backpressure: none; load has priority over shift, idle when neither is asserted.
//
// Ports:
//   i_clock, i_reset      clock and synchronous active-high reset (clears to zero)
//   i_load, i_load_dat    parallel load of the full N-bit value
//   i_shift, i_shift_in   shift right by WIDTH, i_shift_in becomes the top slice
//   o_q                   low OUT_W bits of the register
module slice_shifter #(
    parameter int N     = 32,
    parameter int WIDTH = 8,
    parameter int OUT_W = N
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [N-1:0]     i_load_dat,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_shift_in,
    output logic [OUT_W-1:0] o_q
);

    logic [N-1:0] r_q;
    logic [N-1:0] w_shifted;

    // With a single slice the whole register is replaced by the incoming slice.
    generate
        if (N == WIDTH) begin : g_one_slice
            assign w_shifted = i_shift_in;
        end else begin : g_multi_slice
            assign w_shifted = {i_shift_in, r_q[N-1:WIDTH]};
        end
    endgenerate

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_dat;
        end else if (i_shift) begin
            r_q <= w_shifted;
        end
    end

    assign o_q = r_q[OUT_W-1:0];

endmodule

// File: rtl/wide_add_sequencer.sv
// Purpose : WIDTH*WORDS-bit add/subtract by feeding one slice per cycle through an external WIDTH-bit adder.
// Latency : accept in cycle 0, done pulse in cycle WORDS+1, ready again in cycle WORDS+2.
// Backpressure: o_ready is high only in IDLE; i_start while busy is dropped, never queued.
//
// Ports:
//   i_clock, i_reset              clock and synchronous active-high reset
//   i_start, i_sub, i_carry_in    request, subtract select, add carry (all sampled on accept)
//   i_x, i_y                      N-bit operands sampled on accept
//   o_ready, o_done               idle indicator and one-cycle result-valid pulse
//   o_z, o_carry_out              N-bit result and top carry (for subtract 1 = no borrow)
//   o_add_x, o_add_y, o_add_carry_in   registered slice operands to the external adder
//   i_add_z, i_add_carry_out      combinational sum/carry returned by the external adder
module wide_add_sequencer
    import adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int WORDS = 4,
    localparam int N    = WIDTH * WORDS
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_sub,
    input  logic             i_carry_in,
    input  logic [N-1:0]     i_x,
    input  logic [N-1:0]     i_y,
    output logic             o_ready,
    output logic             o_done,
    output logic [N-1:0]     o_z,
    output logic             o_carry_out,
    output logic [WIDTH-1:0] o_add_x,
    output logic [WIDTH-1:0] o_add_y,
    output logic             o_add_carry_in,
    input  logic [WIDTH-1:0] i_add_z,
    input  logic             i_add_carry_out
);

    localparam int            CW   = cnt_width(WORDS);
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    ctrl_state_e   r_state;
    ctrl_state_e   w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_carry;
    logic          w_accept;
    logic          w_run;
    logic [N-1:0]  w_y_ld;

    assign w_accept = (r_state == ST_IDLE) && i_start;
    assign w_run    = (r_state == ST_RUN);
    // Subtraction is x + ~y + 1: invert B at load and force the initial carry.
    assign w_y_ld   = i_sub ? ~i_y : i_y;

    // ---------------- FSM ----------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_ready     = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (i_start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == LAST) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                o_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ---------------- carry chain and slice counter ----------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_carry <= i_sub | i_carry_in;
            r_cnt   <= '0;
        end else if (w_run) begin
            r_carry <= i_add_carry_out;
            // Hold at the last slice rather than wrapping; the next accept clears it.
            if (r_cnt != LAST) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // ---------------- operand and result registers ----------------
    slice_shifter #(.N(N), .WIDTH(WIDTH), .OUT_W(WIDTH)) u_a (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_load     (w_accept),
        .i_load_dat (i_x),
        .i_shift    (w_run),
        .i_shift_in ({WIDTH{1'b0}}),
        .o_q        (o_add_x)
    );

    slice_shifter #(.N(N), .WIDTH(WIDTH), .OUT_W(WIDTH)) u_b (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_load     (w_accept),
        .i_load_dat (w_y_ld),
        .i_shift    (w_run),
        .i_shift_in ({WIDTH{1'b0}}),
        .o_q        (o_add_y)
    );

    // Result fills from the top; after WORDS shifts slice 0 sits in the low bits.
    slice_shifter #(.N(N), .WIDTH(WIDTH), .OUT_W(N)) u_res (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_load     (1'b0),
        .i_load_dat ({N{1'b0}}),
        .i_shift    (w_run),
        .i_shift_in (i_add_z),
        .o_q        (o_z)
    );

    assign o_add_carry_in = r_carry;
    assign o_carry_out    = r_carry;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Purpose : randomized and directed bench for wide_add_sequencer with an attached behavioural slice adder.
// Latency : expects done WORDS+1 cycles after accept.
// Backpressure: exercises start held high while busy.
module tb_wide_add_sequencer;

    localparam int WIDTH = 8;
    localparam int WORDS = 4;
    localparam int N     = WIDTH * WORDS;

    logic             clk;
    logic             rst;
    logic             start;
    logic             sub;
    logic             cin;
    logic [N-1:0]     x;
    logic [N-1:0]     y;
    logic             ready;
    logic             done;
    logic [N-1:0]     z;
    logic             cout;
    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic             add_ci;
    logic [WIDTH-1:0] add_z;
    logic             add_co;

    int n_vec = 0;
    int n_err = 0;

    wide_add_sequencer #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .i_clock         (clk),
        .i_reset         (rst),
        .i_start         (start),
        .i_sub           (sub),
        .i_carry_in      (cin),
        .i_x             (x),
        .i_y             (y),
        .o_ready         (ready),
        .o_done          (done),
        .o_z             (z),
        .o_carry_out     (cout),
        .o_add_x         (add_x),
        .o_add_y         (add_y),
        .o_add_carry_in  (add_ci),
        .i_add_z         (add_z),
        .i_add_carry_out (add_co)
    );

    // Attached slice adder: purely combinational.
    assign {add_co, add_z} = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_ci};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference: {carry_out, z} from plain N-bit arithmetic.
    function automatic logic [N:0] ref_op(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic s, input logic c);
        logic [N:0] r;
        if (s) begin
            r[N-1:0] = a - b;
            r[N]     = (a >= b);
        end else begin
            r = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [N-1:0] ox, input logic [N-1:0] oy,
                          input logic os, input logic oc);
        logic [N:0]   e;
        logic [N-1:0] ny;
        int           c;
        e  = ref_op(ox, oy, os, oc);
        ny = os ? ~oy : oy;
        check("ready_idle", ready, 1);
        start = 1'b1; x = ox; y = oy; sub = os; cin = oc;
        tick();
        c = 1;
        start = 1'b0; x = $urandom; y = $urandom; sub = 1'($urandom); cin = 1'($urandom);
        check("ready_run", ready, 0);
        check("add_x_slice0", add_x, ox[WIDTH-1:0]);
        check("add_y_slice0", add_y, ny[WIDTH-1:0]);
        check("add_cin_slice0", add_ci, os | oc);
        while (!done && c < 20) begin
            tick();
            c++;
        end
        check("done_cycle", c, WORDS + 1);
        check("z", z, e[N-1:0]);
        check("carry_out", cout, e[N]);
        tick();
        check("done_pulse", done, 0);
        check("ready_after", ready, 1);
        check("z_hold", z, e[N-1:0]);
        check("carry_hold", cout, e[N]);
    endtask

    logic [N-1:0] hx [2];
    logic [N-1:0] hy [2];
    logic         hs [2];
    logic         hc [2];
    logic [N:0]   he;

    initial begin
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; x = '0; y = '0;
        tick();
        tick();
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_z", z, 0);
        check("rst_cout", cout, 0);
        check("rst_add_x", add_x, 0);
        check("rst_add_y", add_y, 0);
        check("rst_add_ci", add_ci, 0);
        rst = 1'b0;
        tick();

        // Directed cases.
        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_op(32'd7, 32'd5, 1'b1, 1'b0);
        run_op(32'd5, 32'd7, 1'b1, 1'b0);
        run_op(32'd0, 32'd0, 1'b0, 1'b1);
        run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0);
        run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);

        // Random operations with random idle gaps.
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            run_op($urandom, $urandom, 1'($urandom), 1'($urandom));
        end

        // Start held high: accepts only in cycles 0 and 6.
        for (int c = 0; c < 12; c++) begin
            check("hold_done", done, (c == 5 || c == 11));
            check("hold_ready", ready, (c == 0 || c == 6));
            if (c == 5) begin
                he = ref_op(hx[0], hy[0], hs[0], hc[0]);
                check("hold_z0", z, he[N-1:0]);
                check("hold_cout0", cout, he[N]);
            end
            if (c == 11) begin
                he = ref_op(hx[1], hy[1], hs[1], hc[1]);
                check("hold_z1", z, he[N-1:0]);
                check("hold_cout1", cout, he[N]);
            end
            start = (c < 11);
            x = $urandom; y = $urandom; sub = 1'($urandom); cin = 1'($urandom);
            if (c == 0) begin
                hx[0] = x; hy[0] = y; hs[0] = sub; hc[0] = cin;
            end
            if (c == 6) begin
                hx[1] = x; hy[1] = y; hs[1] = sub; hc[1] = cin;
            end
            tick();
        end
        start = 1'b0;
        check("hold_ready_end", ready, 1);

        // Reset in cycle 2 of a RUN aborts with no done pulse.
        start = 1'b1; x = $urandom; y = $urandom; sub = 1'b0; cin = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("abort_ready", ready, 1);
        check("abort_z", z, 0);
        check("abort_cout", cout, 0);
        check("abort_done", done, 0);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            check("abort_no_done", done, 0);
        end

        // Reset and start together: reset wins, nothing accepted.
        rst = 1'b1; start = 1'b1; x = 32'h1; y = 32'h1;
        tick();
        check("rst_start_ready", ready, 1);
        rst = 1'b0; start = 1'b0;
        tick();
        check("rst_start_idle", ready, 1);
        check("rst_start_done", done, 0);

        run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
